// File: rtl/binary_onehot_decoder_pipe_pkg.sv
// Shared mode encodings for the binary-to-mask decoder pipeline.
package decoder_pkg;

  localparam logic [1:0] MODE_ONEHOT = 2'b00;
  localparam logic [1:0] MODE_THERMO = 2'b01;
  localparam logic [1:0] MODE_INV    = 2'b10;
  localparam logic [1:0] MODE_CLEAR  = 2'b11;

endpackage

// File: rtl/binary_onehot_decoder_pipe_if.sv
// Index-in / mask-out valid-ready bus between a producer and the decoder pipe.
interface binary_onehot_decoder_pipe_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_idx;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_mask;
  logic             out_oor;

  modport master (
    output in_valid, in_idx, in_mode, out_ready,
    input  in_ready, out_valid, out_mask, out_oor
  );

  modport slave (
    input  in_valid, in_idx, in_mode, out_ready,
    output in_ready, out_valid, out_mask, out_oor
  );

endinterface

// File: rtl/binary_onehot_decoder_pipe_binary_decoder.sv
// Combinational index-to-mask expansion: one-hot, thermometer, inverted one-hot or clear.
module binary_decoder
  import decoder_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  i_idx,
  input  logic [1:0]       i_mode,
  output logic [OUT_W-1:0] o_mask,
  output logic             o_oor
);

  // One extra bit so OUT_W == 2**IN_W is representable in the range compare.
  logic w_in_range;
  assign w_in_range = ({1'b0, i_idx} < (IN_W+1)'(OUT_W));

  always_comb begin
    o_mask = '0;
    o_oor  = 1'b0;
    if (i_mode != MODE_CLEAR) begin
      if (!w_in_range) begin
        o_oor = 1'b1;
      end else begin
        for (int i = 0; i < OUT_W; i++) begin
          case (i_mode)
            MODE_ONEHOT: o_mask[i] = (i_idx == IN_W'(i));
            MODE_THERMO: o_mask[i] = (IN_W'(i) <= i_idx);
            MODE_INV:    o_mask[i] = (i_idx != IN_W'(i));
            default:     o_mask[i] = 1'b0;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/binary_onehot_decoder_pipe.sv
// Decoder front end feeding a 2-entry FIFO output buffer with an accepted-transfer counter.
module binary_onehot_decoder_pipe
  import decoder_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  binary_onehot_decoder_pipe_if.slave bus,
  output logic [CNT_W-1:0]      xfer_cnt
);

  typedef struct packed {
    logic [OUT_W-1:0] mask;
    logic             oor;
  } entry_t;

  logic [OUT_W-1:0] w_dec_mask;
  logic             w_dec_oor;
  entry_t           w_entry;
  entry_t           w_head;
  logic             w_push;
  logic             w_pop;

  logic [1:0]       r_occ;
  logic             r_head;
  logic             r_tail;
  entry_t           r_buf [2];
  logic [CNT_W-1:0] r_xfer_cnt;

  binary_decoder #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_dec (
    .i_idx  (bus.in_idx),
    .i_mode (bus.in_mode),
    .o_mask (w_dec_mask),
    .o_oor  (w_dec_oor)
  );

  assign w_entry = '{mask: w_dec_mask, oor: w_dec_oor};

  // Ready depends only on occupancy, so no combinational path from out_ready.
  assign bus.in_ready  = (r_occ != 2'd2);
  assign bus.out_valid = (r_occ != 2'd0);

  assign w_push = bus.in_valid  & bus.in_ready;
  assign w_pop  = bus.out_valid & bus.out_ready;

  assign w_head       = r_buf[r_head];
  assign bus.out_mask = bus.out_valid ? w_head.mask : '0;
  assign bus.out_oor  = bus.out_valid ? w_head.oor  : 1'b0;
  assign xfer_cnt     = r_xfer_cnt;

  // Control state: occupancy, pointers and transfer counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_occ      <= 2'd0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_xfer_cnt <= '0;
    end else begin
      if (w_push) begin
        r_tail     <= ~r_tail;
        r_xfer_cnt <= r_xfer_cnt + 1'b1;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Buffer storage is data only; stale contents are masked by occupancy.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf[r_tail] <= w_entry;
    end
  end

endmodule

// File: tb/tb_binary_onehot_decoder_pipe.sv
// Scoreboard bench for binary_onehot_decoder_pipe: a 16-bit/16-bit-count and a 10-bit/4-bit-count instance.
module tb_binary_onehot_decoder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  binary_onehot_decoder_pipe_if #(.IN_W(4), .OUT_W(16)) ifa ();
  binary_onehot_decoder_pipe_if #(.IN_W(4), .OUT_W(10)) ifb ();

  binary_onehot_decoder_pipe #(.IN_W(4), .OUT_W(16), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave), .xfer_cnt(cnt_a)
  );

  binary_onehot_decoder_pipe #(.IN_W(4), .OUT_W(10), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave), .xfer_cnt(cnt_b)
  );

  int n_vec = 0;
  int n_err = 0;
  int mon_vec = 0;
  int mon_err = 0;

  logic [16:0] q_a [$];
  logic [10:0] q_b [$];

  // Reference mask: bit 16 is oor, bits [15:0] the mask for a width of ow.
  function automatic logic [16:0] model(input int idx, input int mode, input int ow);
    logic [15:0] m;
    logic        o;
    m = '0;
    o = 1'b0;
    if (mode != 3) begin
      if (idx >= ow) o = 1'b1;
      else begin
        for (int i = 0; i < ow; i++) begin
          if (mode == 0) m[i] = (i == idx);
          else if (mode == 1) m[i] = (i <= idx);
          else m[i] = (i != idx);
        end
      end
    end
    return {o, m};
  endfunction

  // Scoreboard monitors: sample on the falling edge, inputs change just after rising edges.
  logic        hold_a, hold_b;
  logic [16:0] last_a;
  logic [10:0] last_b;

  always @(negedge clk) begin
    logic [16:0] ea;
    logic [16:0] mb;
    logic [10:0] eb;
    if (!rst_n) begin
      q_a.delete();
      q_b.delete();
      hold_a = 1'b0;
      hold_b = 1'b0;
    end else begin
      if (ifa.out_valid) begin
        if (hold_a) begin
          mon_vec++;
          if ({ifa.out_oor, ifa.out_mask} !== last_a) begin
            mon_err++;
            $display("FAIL a_hold_stable got %h want %h", {ifa.out_oor, ifa.out_mask}, last_a);
          end
        end
        if (ifa.out_ready) begin
          mon_vec++;
          if (q_a.size() == 0) begin
            mon_err++;
            $display("FAIL a_unexpected_output got %h want none", {ifa.out_oor, ifa.out_mask});
          end else begin
            ea = q_a.pop_front();
            if ({ifa.out_oor, ifa.out_mask} !== ea) begin
              mon_err++;
              $display("FAIL a_scoreboard got %h want %h", {ifa.out_oor, ifa.out_mask}, ea);
            end
          end
        end
        hold_a = !ifa.out_ready;
        last_a = {ifa.out_oor, ifa.out_mask};
      end else begin
        hold_a = 1'b0;
        mon_vec++;
        if ({ifa.out_oor, ifa.out_mask} !== 17'd0) begin
          mon_err++;
          $display("FAIL a_idle_zero got %h want 0", {ifa.out_oor, ifa.out_mask});
        end
      end
      if (ifb.out_valid) begin
        if (hold_b) begin
          mon_vec++;
          if ({ifb.out_oor, ifb.out_mask} !== last_b) begin
            mon_err++;
            $display("FAIL b_hold_stable got %h want %h", {ifb.out_oor, ifb.out_mask}, last_b);
          end
        end
        if (ifb.out_ready) begin
          mon_vec++;
          if (q_b.size() == 0) begin
            mon_err++;
            $display("FAIL b_unexpected_output got %h want none", {ifb.out_oor, ifb.out_mask});
          end else begin
            eb = q_b.pop_front();
            if ({ifb.out_oor, ifb.out_mask} !== eb) begin
              mon_err++;
              $display("FAIL b_scoreboard got %h want %h", {ifb.out_oor, ifb.out_mask}, eb);
            end
          end
        end
        hold_b = !ifb.out_ready;
        last_b = {ifb.out_oor, ifb.out_mask};
      end else begin
        hold_b = 1'b0;
      end
      if (ifa.in_valid && ifa.in_ready)
        q_a.push_back(model(int'(ifa.in_idx), int'(ifa.in_mode), 16));
      if (ifb.in_valid && ifb.in_ready) begin
        mb = model(int'(ifb.in_idx), int'(ifb.in_mode), 10);
        q_b.push_back({mb[16], mb[9:0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds one request until accepted (bounded); b selects the 10-bit instance.
  task automatic send(input bit b, input int idx, input int mode);
    int n;
    bit rdy;
    n = 0;
    if (b) begin
      ifb.in_valid = 1'b1; ifb.in_idx = 4'(idx); ifb.in_mode = 2'(mode);
    end else begin
      ifa.in_valid = 1'b1; ifa.in_idx = 4'(idx); ifa.in_mode = 2'(mode);
    end
    do begin
      rdy = b ? ifb.in_ready : ifa.in_ready;
      tick();
      n++;
    end while (!rdy && n < 50);
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
    n_vec++;
    if (!rdy) begin
      n_err++;
      $display("FAIL send_timeout got no accept after %0d cycles want accept", n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_idx = 4'd3; ifa.in_mode = 2'd0;
    ifb.in_valid = 1'b1; ifb.in_idx = 4'd3; ifb.in_mode = 2'd0;
    tick();
    tick();
    n_vec++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", ifa.out_valid); end
    n_vec++; if (ifa.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", ifa.in_ready); end
    n_vec++; if (cnt_a !== 16'd0) begin n_err++; $display("FAIL reset_xfer_cnt got %0d want 0", cnt_a); end
    n_vec++; if (ifa.out_mask !== 16'd0 || ifa.out_oor !== 1'b0) begin n_err++; $display("FAIL reset_out_mask got %h/%b want 0/0", ifa.out_mask, ifa.out_oor); end
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    n_vec++; if (ifa.out_valid !== 1'b0 || ifb.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_no_capture got %b%b want 00", ifa.out_valid, ifb.out_valid); end
  endtask

  task automatic test_modes();
    int          idx_t [5] = '{5, 5, 5, 15, 0};
    int          mode_t[5] = '{0, 1, 2, 2, 1};
    logic [15:0] exp_t [5] = '{16'h0020, 16'h003F, 16'hFFDF, 16'h7FFF, 16'h0001};
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(1'b0, idx_t[i], mode_t[i]);
      n_vec++;
      if (ifa.out_valid !== 1'b1 || ifa.out_mask !== exp_t[i] || ifa.out_oor !== 1'b0) begin
        n_err++;
        $display("FAIL mode%0d_idx%0d got v=%b %h oor=%b want v=1 %h oor=0",
                 mode_t[i], idx_t[i], ifa.out_valid, ifa.out_mask, ifa.out_oor, exp_t[i]);
      end
      tick();
    end
  endtask

  task automatic test_oor();
    int          idx_t [5] = '{12, 12, 9, 10, 15};
    int          mode_t[5] = '{0, 3, 1, 2, 0};
    logic [9:0]  exp_t [5] = '{10'h000, 10'h000, 10'h3FF, 10'h000, 10'h000};
    logic        oor_t [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    ifb.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(1'b1, idx_t[i], mode_t[i]);
      n_vec++;
      if (ifb.out_valid !== 1'b1 || ifb.out_mask !== exp_t[i] || ifb.out_oor !== oor_t[i]) begin
        n_err++;
        $display("FAIL oor_mode%0d_idx%0d got v=%b %h oor=%b want v=1 %h oor=%b",
                 mode_t[i], idx_t[i], ifb.out_valid, ifb.out_mask, ifb.out_oor, exp_t[i], oor_t[i]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    ifa.out_ready = 1'b0;
    send(1'b0, 1, 0);
    send(1'b0, 2, 0);
    n_vec++; if (ifa.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready got %b want 0", ifa.in_ready); end
    ifa.in_valid = 1'b1; ifa.in_idx = 4'd3; ifa.in_mode = 2'd0;
    tick();
    tick();
    n_vec++; if (ifa.in_ready !== 1'b0 || ifa.out_mask !== 16'h0002) begin n_err++; $display("FAIL bp_hold got rdy=%b %h want rdy=0 0002", ifa.in_ready, ifa.out_mask); end
    ifa.out_ready = 1'b1;
    tick();
    n_vec++; if (ifa.out_mask !== 16'h0004 || ifa.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_second got %h rdy=%b want 0004 rdy=1", ifa.out_mask, ifa.in_ready); end
    tick();
    n_vec++; if (ifa.out_mask !== 16'h0008 || ifa.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_third got %h v=%b want 0008 v=1", ifa.out_mask, ifa.out_valid); end
    ifa.in_valid = 1'b0;
    tick();
    n_vec++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got v=%b want 0", ifa.out_valid); end
  endtask

  task automatic test_stream();
    logic [15:0] start;
    int          k;
    bit          v, rdy;
    start = cnt_a;
    k = 0;
    for (int c = 0; c < 100; c++) begin
      v = 1'($urandom_range(0, 1));
      ifa.in_valid  = v;
      ifa.in_idx    = 4'($urandom_range(0, 15));
      ifa.in_mode   = 2'($urandom_range(0, 3));
      ifa.out_ready = (c < 50) ? 1'b1 : 1'($urandom_range(0, 1));
      rdy = ifa.in_ready;
      tick();
      if (v && rdy) k++;
    end
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b1;
    tick(); tick(); tick();
    n_vec++; if (cnt_a !== 16'(start + 16'(k))) begin n_err++; $display("FAIL stream_xfer_cnt got %0d want %0d", cnt_a, 16'(start + 16'(k))); end
    n_vec++; if (ifa.out_valid !== 1'b0 || q_a.size() != 0) begin n_err++; $display("FAIL stream_drain got v=%b pending=%0d want v=0 pending=0", ifa.out_valid, q_a.size()); end
  endtask

  task automatic test_wrap();
    int k;
    bit rdy;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ifb.out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 17; c++) begin
      ifb.in_valid = 1'b1;
      ifb.in_idx   = 4'(c);
      ifb.in_mode  = 2'(c % 4);
      rdy = ifb.in_ready;
      tick();
      if (rdy) k++;
    end
    ifb.in_valid = 1'b0;
    n_vec++; if (cnt_b !== 4'd1 || k != 17) begin n_err++; $display("FAIL wrap_xfer_cnt got %0d (accepts %0d) want 1 (accepts 17)", cnt_b, k); end
    tick(); tick();
  endtask

  task automatic test_reset_full();
    ifa.out_ready = 1'b0;
    send(1'b0, 7, 0);
    send(1'b0, 8, 1);
    n_vec++; if (ifa.in_ready !== 1'b0 || ifa.out_valid !== 1'b1) begin n_err++; $display("FAIL rf_full got rdy=%b v=%b want rdy=0 v=1", ifa.in_ready, ifa.out_valid); end
    rst_n = 1'b0;
    tick();
    n_vec++; if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1) begin n_err++; $display("FAIL rf_state got v=%b rdy=%b want v=0 rdy=1", ifa.out_valid, ifa.in_ready); end
    n_vec++; if (cnt_a !== 16'd0 || ifa.out_mask !== 16'd0) begin n_err++; $display("FAIL rf_cnt_mask got %0d %h want 0 0000", cnt_a, ifa.out_mask); end
    rst_n = 1'b1;
    ifa.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++; if (ifa.out_valid !== 1'b0) begin n_err++; $display("FAIL rf_stale got v=%b %h want v=0", ifa.out_valid, ifa.out_mask); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_idx = '0; ifa.in_mode = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_idx = '0; ifb.in_mode = '0; ifb.out_ready = 1'b1;
    hold_a = 1'b0; hold_b = 1'b0; last_a = '0; last_b = '0;
    test_reset();
    test_modes();
    test_oor();
    test_backpressure();
    test_stream();
    test_wrap();
    test_reset_full();
    tick();
    n_vec += mon_vec;
    n_err += mon_err;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
